// File: rtl/patch_slot_manager.sv
// Feature-patch slot table: fills free slots, replaces the weakest slot, then
// re-scans the table one entry per cycle to find the new weakest slot.
module patch_slot_manager #(
  parameter  int IMG_W     = 376,
  parameter  int IMG_H     = 240,
  parameter  int BORDER    = 7,
  parameter  int NUM_SLOTS = 100,
  parameter  int SCORE_W   = 15,
  localparam int ID_W      = $clog2(NUM_SLOTS + 1),
  localparam int X_W       = $clog2(IMG_W),
  localparam int Y_W       = $clog2(IMG_H)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               pix_valid,
  input  logic [Y_W-1:0]     row_cnt,
  input  logic [X_W-1:0]     col_cnt,
  input  logic               is_fast,
  input  logic [SCORE_W-1:0] new_score,
  input  logic [IMG_H-1:0]   ban_rows,
  input  logic [IMG_W-1:0]   ban_cols,
  output logic               renew_valid,
  output logic [ID_W-1:0]    renew_id,
  output logic [X_W-1:0]     renew_x,
  output logic [Y_W-1:0]     renew_y,
  output logic               renew_fill,
  output logic [SCORE_W-1:0] worst_score,
  output logic [ID_W-1:0]    worst_id,
  output logic [ID_W-1:0]    fill_count,
  output logic               busy,
  output logic [15:0]        drop_cnt
);

  typedef enum logic {READY, SCAN} state_t;

  localparam logic [ID_W-1:0] NONE_ID = ID_W'(NUM_SLOTS);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_SLOTS - 1);
  localparam logic [Y_W-1:0]  ROW_LO  = Y_W'(BORDER);
  localparam logic [Y_W-1:0]  ROW_HI  = Y_W'(IMG_H - BORDER);
  localparam logic [X_W-1:0]  COL_LO  = X_W'(BORDER);
  localparam logic [X_W-1:0]  COL_HI  = X_W'(IMG_W - BORDER);

  state_t state, state_nxt;

  logic [SCORE_W-1:0] score_mem [NUM_SLOTS];
  logic [X_W-1:0]     x_mem     [NUM_SLOTS];
  logic [Y_W-1:0]     y_mem     [NUM_SLOTS];

  logic [ID_W-1:0]    scan_idx;
  logic [SCORE_W-1:0] scan_min;
  logic [ID_W-1:0]    scan_min_id;
  logic [SCORE_W-1:0] scan_score;

  logic in_border, banned, qualify, full;
  logic accept_fill, accept_repl, scan_take, scan_last;
  logic [ID_W-1:0] wr_idx;

  assign in_border = (row_cnt >= ROW_LO) && (row_cnt <= ROW_HI) &&
                     (col_cnt >= COL_LO) && (col_cnt <= COL_HI);
  assign banned    = ban_rows[row_cnt] & ban_cols[col_cnt];
  assign qualify   = pix_valid & is_fast & in_border & ~banned;
  assign full      = (fill_count == NONE_ID);

  assign accept_fill = (state == READY) & ~clear & qualify & ~full;
  assign accept_repl = (state == READY) & ~clear & qualify & full &
                       (new_score > worst_score);
  assign wr_idx      = accept_fill ? fill_count : worst_id;

  // Slot 0 seeds the running minimum; strict < keeps the lowest index on ties.
  assign scan_score = score_mem[scan_idx];
  assign scan_take  = (scan_idx == '0) || (scan_score < scan_min);
  assign scan_last  = (scan_idx == LAST_ID);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values regardless of statement order.
    if (rst) state <= READY;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: default assignment first so no path leaves state_nxt unassigned
    // (which would infer a latch).
    state_nxt = state;
    if (clear) begin
      state_nxt = READY;
    end else begin
      case (state)
        READY:   if (accept_repl) state_nxt = SCAN;
        SCAN:    if (scan_last)   state_nxt = READY;
        default: state_nxt = READY;
      endcase
    end
  end

  always_comb begin
    busy = (state == SCAN);
  end

  // NOTE: the slot table is deliberately not reset; entries at index >=
  // fill_count are never read as valid, and leaving the RAM unreset lets it
  // map onto plain memory.
  always_ff @(posedge clk) begin
    if (accept_fill || accept_repl) begin
      score_mem[wr_idx] <= new_score;
      x_mem[wr_idx]     <= col_cnt;
      y_mem[wr_idx]     <= row_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      renew_valid <= 1'b0;
      renew_id    <= NONE_ID;
      renew_x     <= '0;
      renew_y     <= '0;
      renew_fill  <= 1'b0;
      worst_score <= '1;
      worst_id    <= NONE_ID;
      fill_count  <= '0;
      drop_cnt    <= '0;
      scan_idx    <= '0;
      scan_min    <= '1;
      scan_min_id <= NONE_ID;
    end else begin
      renew_valid <= 1'b0;
      renew_id    <= NONE_ID;
      if (clear) begin
        fill_count  <= '0;
        worst_score <= '1;
        worst_id    <= NONE_ID;
        drop_cnt    <= '0;
      end else begin
        if (accept_fill || accept_repl) begin
          renew_valid <= 1'b1;
          renew_id    <= wr_idx;
          renew_x     <= col_cnt;
          renew_y     <= row_cnt;
          renew_fill  <= accept_fill;
        end
        if (accept_fill) begin
          fill_count <= fill_count + ID_W'(1);
          if ((fill_count == '0) || (new_score < worst_score)) begin
            worst_score <= new_score;
            worst_id    <= fill_count;
          end
        end
        if (accept_repl) scan_idx <= '0;
        if (state == SCAN) begin
          if (qualify && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
          if (scan_take) begin
            scan_min    <= scan_score;
            scan_min_id <= scan_idx;
          end
          scan_idx <= scan_idx + ID_W'(1);
          if (scan_last) begin
            worst_score <= scan_take ? scan_score : scan_min;
            worst_id    <= scan_take ? scan_idx   : scan_min_id;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_patch_slot_manager.sv
// Bench for patch_slot_manager: directed scenarios with literal expectations,
// then random traffic, all compared every cycle against a table-level model.
module tb_patch_slot_manager;

  localparam int IMG_W     = 376;
  localparam int IMG_H     = 240;
  localparam int BORDER    = 7;
  localparam int NUM_SLOTS = 100;
  localparam int SCORE_W   = 15;
  localparam int ID_W      = $clog2(NUM_SLOTS + 1);
  localparam int X_W       = $clog2(IMG_W);
  localparam int Y_W       = $clog2(IMG_H);
  localparam int MAX_SCORE = (1 << SCORE_W) - 1;

  logic               clk = 1'b0;
  logic               rst, clear, pix_valid, is_fast;
  logic [Y_W-1:0]     row_cnt;
  logic [X_W-1:0]     col_cnt;
  logic [SCORE_W-1:0] new_score;
  logic [IMG_H-1:0]   ban_rows;
  logic [IMG_W-1:0]   ban_cols;
  logic               renew_valid, renew_fill, busy;
  logic [ID_W-1:0]    renew_id, worst_id, fill_count;
  logic [X_W-1:0]     renew_x;
  logic [Y_W-1:0]     renew_y;
  logic [SCORE_W-1:0] worst_score;
  logic [15:0]        drop_cnt;

  always #5 clk = ~clk;

  patch_slot_manager #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .BORDER(BORDER),
    .NUM_SLOTS(NUM_SLOTS), .SCORE_W(SCORE_W)
  ) dut (
    .clk(clk), .rst(rst), .clear(clear), .pix_valid(pix_valid),
    .row_cnt(row_cnt), .col_cnt(col_cnt), .is_fast(is_fast),
    .new_score(new_score), .ban_rows(ban_rows), .ban_cols(ban_cols),
    .renew_valid(renew_valid), .renew_id(renew_id), .renew_x(renew_x),
    .renew_y(renew_y), .renew_fill(renew_fill), .worst_score(worst_score),
    .worst_id(worst_id), .fill_count(fill_count), .busy(busy),
    .drop_cnt(drop_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input longint actual, input longint expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference model: the table as a plain array, the scan as a countdown
  // followed by an instantaneous lowest-index minimum.
  int  m_score [NUM_SLOTS];
  int  m_fill, m_worst, m_worst_id, m_busy_left, m_drop;
  bit  e_valid, e_fill;
  int  e_id, e_x, e_y;

  function automatic bit qualifies();
    int r, c;
    r = int'(row_cnt);
    c = int'(col_cnt);
    if (!(pix_valid && is_fast)) return 1'b0;
    if (r < BORDER || r > IMG_H - BORDER || c < BORDER || c > IMG_W - BORDER) return 1'b0;
    return !(ban_rows[r] && ban_cols[c]);
  endfunction

  always @(posedge clk) begin
    bit q;
    int s;
    q = qualifies();
    s = int'(new_score);
    if (rst) begin
      m_fill = 0; m_worst = MAX_SCORE; m_worst_id = NUM_SLOTS;
      m_busy_left = 0; m_drop = 0;
      e_valid = 0; e_id = NUM_SLOTS; e_x = 0; e_y = 0; e_fill = 0;
    end else begin
      e_valid = 0;
      e_id    = NUM_SLOTS;
      if (clear) begin
        m_fill = 0; m_worst = MAX_SCORE; m_worst_id = NUM_SLOTS;
        m_busy_left = 0; m_drop = 0;
      end else if (m_busy_left > 0) begin
        if (q && m_drop < 65535) m_drop++;
        m_busy_left--;
        if (m_busy_left == 0) begin
          m_worst = m_score[0];
          m_worst_id = 0;
          for (int i = 1; i < NUM_SLOTS; i++)
            if (m_score[i] < m_worst) begin m_worst = m_score[i]; m_worst_id = i; end
        end
      end else if (q) begin
        if (m_fill < NUM_SLOTS) begin
          m_score[m_fill] = s;
          e_valid = 1; e_id = m_fill; e_fill = 1;
          e_x = int'(col_cnt); e_y = int'(row_cnt);
          if (m_fill == 0 || s < m_worst) begin m_worst = s; m_worst_id = m_fill; end
          m_fill++;
        end else if (s > m_worst) begin
          m_score[m_worst_id] = s;
          e_valid = 1; e_id = m_worst_id; e_fill = 0;
          e_x = int'(col_cnt); e_y = int'(row_cnt);
          m_busy_left = NUM_SLOTS;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("renew_valid", renew_valid, e_valid);
    check("renew_id", renew_id, e_id);
    if (e_valid) begin
      check("renew_x", renew_x, e_x);
      check("renew_y", renew_y, e_y);
      check("renew_fill", renew_fill, e_fill);
    end
    check("fill_count", fill_count, m_fill);
    check("busy", busy, m_busy_left > 0);
    check("drop_cnt", drop_cnt, m_drop);
    if (m_busy_left == 0) begin
      check("worst_score", worst_score, m_worst);
      check("worst_id", worst_id, m_worst_id);
    end
  end

  task automatic drive(input bit v, input int r, input int c, input bit f, input int s);
    pix_valid = v; row_cnt = Y_W'(r); col_cnt = X_W'(c);
    is_fast = f; new_score = SCORE_W'(s);
    @(negedge clk);
    pix_valid = 1'b0; is_fast = 1'b0;
  endtask

  task automatic cand(input int s);
    drive(1'b1, $urandom_range(BORDER, IMG_H - BORDER),
          $urandom_range(BORDER, IMG_W - BORDER), 1'b1, s);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic wait_not_busy();
    int guard;
    guard = 0;
    while (busy && guard < 300) begin guard++; idle(1); end
    check("scan_timeout", guard < 300, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cycles, guard, s;
    rst = 1'b1; clear = 1'b0; pix_valid = 1'b0; is_fast = 1'b0;
    row_cnt = '0; col_cnt = '0; new_score = '0; ban_rows = '0; ban_cols = '0;
    idle(2);
    rst = 1'b0;
    check("rst_renew_valid", renew_valid, 0);
    check("rst_renew_id", renew_id, 100);
    check("rst_renew_xy", {renew_x, renew_y}, 0);
    check("rst_worst_score", worst_score, 32767);
    check("rst_worst_id", worst_id, 100);
    check("rst_fill_busy_drop", {fill_count, busy, drop_cnt}, 0);

    for (int i = 0; i < 10; i++)
      drive(1'b1, $urandom_range(0, IMG_H - 1), $urandom_range(0, IMG_W - 1), 1'b0,
            $urandom_range(0, MAX_SCORE));

    drive(1'b1, 6, 50, 1'b1, 100);
    check("border_row6", renew_valid, 0);
    drive(1'b1, 7, 7, 1'b1, 100);
    check("corner_valid", renew_valid, 1);
    check("corner_id", renew_id, 0);
    check("corner_fill", renew_fill, 1);
    drive(1'b1, 233, 369, 1'b1, 100);
    check("upper_border_id", renew_id, 1);
    drive(1'b1, 234, 50, 1'b1, 100);
    check("row234_rejected", renew_valid, 0);

    ban_rows[20] = 1'b1; ban_cols[30] = 1'b1;
    drive(1'b1, 20, 30, 1'b1, 100);
    check("banned", renew_valid, 0);
    drive(1'b1, 20, 31, 1'b1, 100);
    check("ban_neighbour_id", renew_id, 2);
    ban_rows = '0; ban_cols = '0;

    pulse_clear();
    check("clear_fill", fill_count, 0);
    for (int i = 0; i < NUM_SLOTS; i++) begin
      cand(500 - i);
      check("fill_id", renew_id, i);
      check("fill_no_busy", busy, 0);
    end
    check("full_count", fill_count, 100);
    check("full_worst_score", worst_score, 401);
    check("full_worst_id", worst_id, 99);

    cand(401);
    check("equal_ignored", renew_valid, 0);
    cand(600);
    check("replace_id", renew_id, 99);
    check("replace_fill", renew_fill, 0);
    busy_cycles = 0; guard = 0;
    while (busy && guard < 300) begin
      busy_cycles++; guard++;
      if (busy_cycles <= 3) cand(700);
      else idle(1);
    end
    check("busy_cycles", busy_cycles, 100);
    check("scan_worst_score", worst_score, 402);
    check("scan_worst_id", worst_id, 98);
    check("drop_three", drop_cnt, 3);

    pulse_clear();
    for (int i = 0; i < NUM_SLOTS; i++) begin
      s = (i == 5 || i == 40) ? 10 : (i == 70) ? 5 : 1000 + i;
      cand(s);
    end
    check("tie_pre_worst_id", worst_id, 70);
    cand(2000);
    check("tie_replace_id", renew_id, 70);
    wait_not_busy();
    check("tie_worst_score", worst_score, 10);
    check("tie_worst_id", worst_id, 5);

    cand(3000);
    check("abort_replace_id", renew_id, 5);
    idle(49);
    check("abort_busy50", busy, 1);
    pulse_clear();
    check("abort_busy", busy, 0);
    check("abort_fill", fill_count, 0);
    check("abort_drop", drop_cnt, 0);
    check("abort_worst", worst_score, 32767);
    cand(123);
    check("after_abort_id", renew_id, 0);
    check("after_abort_fill", renew_fill, 1);

    for (int cyc = 0; cyc < 6000; cyc++) begin
      rst   = ($urandom_range(0, 1999) == 0);
      clear = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 499) == 0) begin
        for (int i = 0; i < IMG_H; i++) ban_rows[i] = ($urandom_range(0, 3) == 0);
        for (int i = 0; i < IMG_W; i++) ban_cols[i] = ($urandom_range(0, 3) == 0);
      end
      s = ($urandom_range(0, 3) == 0) ? $urandom_range(0, MAX_SCORE) : $urandom_range(0, 63);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, IMG_H - 1),
            $urandom_range(0, IMG_W - 1), $urandom_range(0, 1) == 1, s);
      rst = 1'b0; clear = 1'b0;
    end
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/patch_slot_manager.md
# patch_slot_manager

Parametrised successor to the per-pixel patch-renewal decision. It owns the feature-patch slot table itself: a score/position table of `NUM_SLOTS` entries, a worst-slot tracker and a fill counter, instead of taking the worst slot from outside. It sits after the FAST detector/scorer in the pixel stream. It fills free slots first, then replaces the weakest slot, re-scans the table sequentially to find the new worst slot, and reports every renewal to the downstream patch-extraction logic.

## Interface
- `IMG_W`, 376, image width in pixels
- `IMG_H`, 240, image height in pixels
- `BORDER`, 7, margin excluded on every side
- `NUM_SLOTS`, 100, patch table depth (≥2)
- `SCORE_W`, 15, score width
- Localparams: `ID_W = clog2(NUM_SLOTS+1)`, `X_W = clog2(IMG_W)`, `Y_W = clog2(IMG_H)`
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `clear`  in  1  one-cycle pulse: empty the table (frame start / re-init)
- `pix_valid`  in  1  `row_cnt`/`col_cnt`/`is_fast`/`new_score` valid this cycle
- `row_cnt`  in  Y_W  pixel row
- `col_cnt`  in  X_W  pixel column
- `is_fast`  in  1  pixel is a FAST corner
- `new_score`  in  SCORE_W  corner score, unsigned
- `ban_rows`  in  IMG_H  per-row ban mask
- `ban_cols`  in  IMG_W  per-column ban mask
- `renew_valid`  out  1  one-cycle renewal pulse
- `renew_id`  out  ID_W  slot renewed; `NUM_SLOTS` when none
- `renew_x`, `renew_y`  out  X_W / Y_W  position written into the slot
- `renew_fill`  out  1  1 = free slot filled, 0 = worst slot replaced
- `worst_score`  out  SCORE_W  current minimum score in the table
- `worst_id`  out  ID_W  slot holding `worst_score`
- `fill_count`  out  ID_W  occupied slots
- `busy`  out  1  re-scan in progress; candidates are dropped
- `drop_cnt`  out  16  qualifying candidates dropped while busy, saturating

## Operation
- A candidate qualifies when all of these hold:
  - `pix_valid & is_fast`
  - Border: `BORDER ≤ row_cnt ≤ IMG_H-BORDER` and `BORDER ≤ col_cnt ≤ IMG_W-BORDER`
  - Not banned: banned means `ban_rows[row_cnt] & ban_cols[col_cnt]`
- States: READY, SCAN.
- In READY, when `fill_count < NUM_SLOTS`, a qualifying candidate:
  - Writes slot `fill_count` with score, x, y.
  - Increments `fill_count`.
  - Asserts `renew_fill=1`.
  - Updates the worst tracker incrementally: first entry, or `new_score < worst_score` strictly, takes the new slot. Ties keep the lower index.
- In READY, when the table is full, a qualifying candidate with `new_score > worst_score` strictly:
  - Overwrites slot `worst_id`.
  - Asserts `renew_fill=0`.
  - Moves to SCAN.
  - A candidate with equal or lower score is ignored: no pulse, no drop count.
- SCAN:
  - Reads slot 0..NUM_SLOTS-1, one per cycle.
  - Keeps a running minimum with strict `<`, so the lowest index wins ties.
  - After the last slot it loads `worst_score`/`worst_id` and returns to READY.
- While in SCAN, qualifying candidates are discarded and `drop_cnt` increments (saturates at 0xFFFF).
- `clear`:
  - Sets `fill_count=0`, `worst_score=all-ones`, `worst_id=NUM_SLOTS`, `drop_cnt=0`.
  - Goes to READY. A SCAN in progress is aborted.
  - Has priority over a same-cycle candidate; that candidate is discarded without a pulse.
- Table contents are not reset; an entry is only considered valid by index `< fill_count`.
- Scores compare unsigned; positions are stored with the native `X_W`/`Y_W` widths.

## Timing
- Reset values:
  - `renew_valid=0`, `renew_id=NUM_SLOTS`, `renew_x=0`, `renew_y=0`, `renew_fill=0`
  - `worst_score=all-ones`, `worst_id=NUM_SLOTS`, `fill_count=0`, `busy=0`, `drop_cnt=0`
  - State READY
- Candidate sampled in cycle t: `renew_*` outputs are registered, valid in cycle t+1 only. Outside a pulse, `renew_id` returns to `NUM_SLOTS`.
- Fill path:
  - `fill_count`/`worst_*` are updated in t+1.
  - Back-to-back candidates are accepted every cycle.
- Replace path:
  - `busy=1` for cycles t+1..t+NUM_SLOTS.
  - New `worst_*` is visible and `busy=0` at t+NUM_SLOTS+1.
  - A candidate is accepted again at t+NUM_SLOTS+1.
- The fill that makes the table full needs no SCAN; the worst slot is already tracked.
- `rst` mid-SCAN returns to the reset state on the next edge.

## Test plan
- **Reset/idle:** assert `rst` 2 cycles → all outputs at reset values; stream non-FAST pixels → no `renew_valid`.
- **Border/ban:**
  - FAST, score 100 at (row 6, col 50) → nothing.
  - At (7,7) → `renew_id=0`, `renew_fill=1`.
  - With `ban_rows[20]=ban_cols[30]=1`, candidate at (20,30) → nothing; (20,31) → slot 1.
- **Fill:** 100 qualifying candidates with scores 500 down to 401 → ids 0..99 in order; `fill_count=100`, `worst_score=401`, `worst_id=99`, `busy` never set.
- **Replace + scan:**
  - Full table, candidate score 401 → ignored.
  - Candidate score 600 → `renew_id=99`, `renew_fill=0`, `busy` high exactly 100 cycles, then `worst_score=402`, `worst_id=98`.
  - 3 candidates during busy → `drop_cnt=3`.
- **Tie in scan:** slots 5 and 40 share minimum 10 → after replace-scan, `worst_id=5`.
- **Clear mid-SCAN:** `clear` at busy cycle 50 → next cycle `busy=0`, `fill_count=0`, `drop_cnt=0`; next candidate → `renew_id=0`.
